// File: rtl/lsu_rr_arbiter_pkg.sv
// Shared definitions for the LSU memory-port arbiter: FSM state encodings and
// response-type constants.
package lsu_rr_arbiter_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;

  // Direction of the captured transaction; also picks the response path.
  localparam logic RESP_READ  = 1'b0;
  localparam logic RESP_WRITE = 1'b1;

endpackage

// File: rtl/lsu_rr_arbiter_if.sv
// LSU-side and memory-side handshake bundle of the arbiter.
interface lsu_rr_arbiter_if #(
  parameter int NUM_REQUESTERS = 64,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8
);
  logic [NUM_REQUESTERS-1:0] req_valid;
  logic [NUM_REQUESTERS-1:0] req_write;
  logic [ADDR_WIDTH-1:0]     req_addr [NUM_REQUESTERS];
  logic [DATA_WIDTH-1:0]     req_data [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0] req_ready;

  logic                      mem_valid;
  logic                      mem_write;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_data;
  logic                      mem_ready;
  logic                      mem_rvalid;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  logic [NUM_REQUESTERS-1:0] resp_valid;
  logic [DATA_WIDTH-1:0]     resp_data;

  // Arbiter side
  modport slave (
    input  req_valid, req_write, req_addr, req_data,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_write, mem_addr, mem_data,
    output resp_valid, resp_data
  );

  // LSU / memory model side
  modport master (
    output req_valid, req_write, req_addr, req_data,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_write, mem_addr, mem_data,
    input  resp_valid, resp_data
  );
endinterface

// File: rtl/lsu_rr_arbiter_rr_select.sv
// Rotating first-set search: scans from last_grant+1 (mod N) and returns the
// first requesting index. Forcing last_grant to N-1 yields lowest-index-wins.
module rr_select #(
  parameter int N = 64,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] winner,
  output logic         found
);

  always_comb begin : search
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N;
      if (req[W'(idx)]) begin
        winner = W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_rr_arbiter.sv
// Single-outstanding arbiter funnelling NUM_REQUESTERS LSU channels onto one
// memory port; round-robin or fixed-priority winner selection.
module lsu_rr_arbiter
  import lsu_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 64,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int FIXED_PRIORITY = 0
) (
  input logic             clk,
  input logic             reset,
  lsu_rr_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [1:0]                state, state_nxt;
  logic [IW-1:0]             last_grant, sel_last, winner, cap_id;
  logic                      found, accept, issue;
  logic                      cap_write;
  logic [ADDR_WIDTH-1:0]     cap_addr;
  logic [DATA_WIDTH-1:0]     cap_data;
  logic [NUM_REQUESTERS-1:0] resp_valid_q;
  logic [DATA_WIDTH-1:0]     resp_data_q;
  logic [NUM_REQUESTERS-1:0] win_oh, id_oh;

  generate
    if (FIXED_PRIORITY != 0) begin : g_fixed
      assign sel_last = IW'(NUM_REQUESTERS - 1);
    end else begin : g_rr
      assign sel_last = last_grant;
    end
  endgenerate

  rr_select #(.N(NUM_REQUESTERS)) u_sel (
    .req        (bus.req_valid),
    .last_grant (sel_last),
    .winner     (winner),
    .found      (found)
  );

  assign accept = (state == ST_IDLE) && found;
  assign issue  = (state == ST_ISSUE);
  assign win_oh = NUM_REQUESTERS'(1) << winner;
  assign id_oh  = NUM_REQUESTERS'(1) << cap_id;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (found) state_nxt = ST_ISSUE;
      ST_ISSUE:     if (bus.mem_ready)
                      state_nxt = (cap_write == RESP_WRITE) ? ST_IDLE : ST_WAIT_RESP;
      ST_WAIT_RESP: if (bus.mem_rvalid) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      last_grant   <= IW'(NUM_REQUESTERS - 1);
      cap_id       <= '0;
      cap_write    <= 1'b0;
      cap_addr     <= '0;
      cap_data     <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      state        <= state_nxt;
      resp_valid_q <= '0;
      if (accept) begin
        last_grant <= winner;
        cap_id     <= winner;
        cap_write  <= bus.req_write[winner];
        cap_addr   <= bus.req_addr[winner];
        cap_data   <= bus.req_data[winner];
      end
      // Write ack issues as soon as memory takes the request.
      if (issue && bus.mem_ready && cap_write == RESP_WRITE) begin
        resp_valid_q <= id_oh;
        resp_data_q  <= '0;
      end
      if (state == ST_WAIT_RESP && bus.mem_rvalid) begin
        resp_valid_q <= id_oh;
        resp_data_q  <= bus.mem_rdata;
      end
    end
  end

  // Accept pulse is combinational so the LSU sees it in the capture cycle;
  // gating with reset keeps it quiet while reset is held.
  assign bus.req_ready  = (accept && reset) ? win_oh : '0;
  assign bus.mem_valid  = issue;
  assign bus.mem_write  = issue & cap_write;
  assign bus.mem_addr   = issue ? cap_addr : '0;
  assign bus.mem_data   = issue ? cap_data : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_lsu_rr_arbiter.sv
// Directed bench for lsu_rr_arbiter with N=4: vector table plus corner sequences.
module tb_lsu_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_rr_arbiter_if #(.NUM_REQUESTERS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
  lsu_rr_arbiter_if #(.NUM_REQUESTERS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8)) bus_fp ();

  lsu_rr_arbiter #(.NUM_REQUESTERS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );
  lsu_rr_arbiter #(.NUM_REQUESTERS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(rst_n), .bus(bus_fp)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] rv, rw;
    logic       mrdy, rvld;
    logic [7:0] rdata;
    logic [3:0] e_rr;
    logic       e_mv, e_mw;
    logic [7:0] e_ma, e_md;
    logic [3:0] e_resp;
    logic [7:0] e_rd;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] rv, logic [3:0] rw, logic mrdy, logic rvld,
                              logic [7:0] rdata, logic [3:0] e_rr, logic e_mv, logic e_mw,
                              logic [7:0] e_ma, logic [7:0] e_md, logic [3:0] e_resp,
                              logic [7:0] e_rd);
    vec_t v;
    v.rst_n = r; v.rv = rv; v.rw = rw; v.mrdy = mrdy; v.rvld = rvld; v.rdata = rdata;
    v.e_rr = e_rr; v.e_mv = e_mv; v.e_mw = e_mw; v.e_ma = e_ma; v.e_md = e_md;
    v.e_resp = e_resp; v.e_rd = e_rd;
    return v;
  endfunction

  vec_t tbl[21];

  initial begin
    rst_n = 1'b1;
    bus.req_valid = '0; bus.req_write = '0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.req_addr[0] = 8'h10; bus.req_addr[1] = 8'h11;
    bus.req_addr[2] = 8'h3C; bus.req_addr[3] = 8'h13;
    for (int i = 0; i < 4; i++) bus.req_data[i] = 8'h20 + 8'(i);

    bus_fp.req_valid = 4'b1010; bus_fp.req_write = 4'b1111;
    bus_fp.mem_ready = 1'b1; bus_fp.mem_rvalid = 1'b0; bus_fp.mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      bus_fp.req_addr[i] = 8'h40 + 8'(i);
      bus_fp.req_data[i] = 8'h50 + 8'(i);
    end

    //            rst rv    rw    rdy vld rdata  rr    mv mw ma     md     resp  rd
    tbl[0]  = mk(0, 4'hF, 4'hF, 1, 0, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 4'h0, 8'h00);
    tbl[1]  = mk(1, 4'hF, 4'hF, 1, 0, 8'h00, 4'h1, 0, 0, 8'h00, 8'h00, 4'h0, 8'h00);
    tbl[2]  = mk(1, 4'hF, 4'hF, 1, 0, 8'h00, 4'h0, 1, 1, 8'h10, 8'h20, 4'h0, 8'h00);
    tbl[3]  = mk(1, 4'hF, 4'hF, 1, 0, 8'h00, 4'h2, 0, 0, 8'h00, 8'h00, 4'h1, 8'h00);
    tbl[4]  = mk(1, 4'hF, 4'hF, 1, 0, 8'h00, 4'h0, 1, 1, 8'h11, 8'h21, 4'h0, 8'h00);
    tbl[5]  = mk(1, 4'hF, 4'hF, 1, 0, 8'h00, 4'h4, 0, 0, 8'h00, 8'h00, 4'h2, 8'h00);
    tbl[6]  = mk(1, 4'hF, 4'hF, 1, 0, 8'h00, 4'h0, 1, 1, 8'h3C, 8'h22, 4'h0, 8'h00);
    tbl[7]  = mk(1, 4'hF, 4'hF, 1, 0, 8'h00, 4'h8, 0, 0, 8'h00, 8'h00, 4'h4, 8'h00);
    tbl[8]  = mk(1, 4'hF, 4'hF, 1, 0, 8'h00, 4'h0, 1, 1, 8'h13, 8'h23, 4'h0, 8'h00);
    tbl[9]  = mk(1, 4'hF, 4'hF, 1, 0, 8'h00, 4'h1, 0, 0, 8'h00, 8'h00, 4'h8, 8'h00);
    tbl[10] = mk(1, 4'h0, 4'hF, 1, 0, 8'h00, 4'h0, 1, 1, 8'h10, 8'h20, 4'h0, 8'h00);
    tbl[11] = mk(1, 4'h0, 4'hF, 1, 1, 8'h77, 4'h0, 0, 0, 8'h00, 8'h00, 4'h1, 8'h00);
    tbl[12] = mk(1, 4'h0, 4'hF, 1, 0, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 4'h0, 8'h00);
    tbl[13] = mk(1, 4'h4, 4'h0, 0, 0, 8'h00, 4'h4, 0, 0, 8'h00, 8'h00, 4'h0, 8'h00);
    tbl[14] = mk(1, 4'h4, 4'h0, 0, 0, 8'h00, 4'h0, 1, 0, 8'h3C, 8'h22, 4'h0, 8'h00);
    tbl[15] = mk(1, 4'h4, 4'h0, 0, 0, 8'h00, 4'h0, 1, 0, 8'h3C, 8'h22, 4'h0, 8'h00);
    tbl[16] = mk(1, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 1, 0, 8'h3C, 8'h22, 4'h0, 8'h00);
    tbl[17] = mk(1, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 4'h0, 8'h00);
    tbl[18] = mk(1, 4'h0, 4'h0, 0, 1, 8'hA5, 4'h0, 0, 0, 8'h00, 8'h00, 4'h0, 8'h00);
    tbl[19] = mk(1, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 4'h4, 8'hA5);
    tbl[20] = mk(1, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 4'h0, 8'h00);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      rst_n          = tbl[i].rst_n;
      bus.req_valid  = tbl[i].rv;
      bus.req_write  = tbl[i].rw;
      bus.mem_ready  = tbl[i].mrdy;
      bus.mem_rvalid = tbl[i].rvld;
      bus.mem_rdata  = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rr));
      chk($sformatf("v%0d mem_valid", i), 32'(bus.mem_valid), 32'(tbl[i].e_mv));
      chk($sformatf("v%0d mem_write", i), 32'(bus.mem_write), 32'(tbl[i].e_mw));
      chk($sformatf("v%0d mem_addr", i),  32'(bus.mem_addr),  32'(tbl[i].e_ma));
      chk($sformatf("v%0d mem_data", i),  32'(bus.mem_data),  32'(tbl[i].e_md));
      chk($sformatf("v%0d resp_valid", i), 32'(bus.resp_valid), 32'(tbl[i].e_resp));
      if (tbl[i].e_rd != 8'h00)
        chk($sformatf("v%0d resp_data", i), 32'(bus.resp_data), 32'(tbl[i].e_rd));
    end

    // Requester 0 changes address and drops valid right after its accept.
    @(negedge clk); rst_n = 1'b0; bus.req_valid = '0; bus.mem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bus.req_addr[0] = 8'h55;
    @(negedge clk); bus.req_valid = 4'b0001; bus.req_write = 4'b0000; #1;
    chk("drop accept", 32'(bus.req_ready), 32'h1);
    @(negedge clk); bus.req_addr[0] = 8'h99; bus.req_valid = '0; #1;
    chk("drop issue valid", 32'(bus.mem_valid), 32'h1);
    chk("drop issue addr", 32'(bus.mem_addr), 32'h55);
    @(negedge clk); bus.mem_ready = 1'b1; #1;
    chk("drop issue addr hold", 32'(bus.mem_addr), 32'h55);
    @(negedge clk); bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'h3E; #1;
    chk("drop wait valid", 32'(bus.mem_valid), 32'h0);
    @(negedge clk); bus.mem_rvalid = 1'b0; #1;
    chk("drop resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("drop resp_data", 32'(bus.resp_data), 32'h3E);
    bus.req_addr[0] = 8'h10;

    // Reset while LSU 1 waits for read data; late rvalid must be ignored.
    @(negedge clk); bus.req_valid = 4'b0010; bus.req_write = 4'b0000; bus.mem_ready = 1'b1; #1;
    chk("rst accept lsu1", 32'(bus.req_ready), 32'h2);
    @(negedge clk); bus.req_valid = '0; #1;
    chk("rst issue addr", 32'(bus.mem_addr), 32'h11);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rst mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'h0);
    @(negedge clk); rst_n = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'h5A; #1;
    chk("rst late rvalid a", 32'(bus.resp_valid), 32'h0);
    @(negedge clk); bus.mem_rvalid = 1'b0; #1;
    chk("rst late rvalid b", 32'(bus.resp_valid), 32'h0);
    @(negedge clk); bus.req_valid = 4'b1111; #1;
    chk("rst next grant", 32'(bus.req_ready), 32'h1);

    // Fixed priority: LSU 1 always wins over LSU 3.
    @(negedge clk); rst_n = 1'b0; bus.req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("fp c%0d req_ready", i), 32'(bus_fp.req_ready),
          (i % 2 == 0) ? 32'h2 : 32'h0);
      chk($sformatf("fp c%0d resp_valid", i), 32'(bus_fp.resp_valid),
          (i > 0 && i % 2 == 0) ? 32'h2 : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
